// File: rtl/fifo_burst_ctrl_if.sv
// Burst handshake and status bundle between the FIFO controller and its row producer/consumer.
// master drives the requests; slave is the controller.
`timescale 1ns/1ps

interface fifo_burst_ctrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int LEN_WIDTH  = 3
);
   logic                  wr;
   logic [LEN_WIDTH-1:0]  wr_len;
   logic                  rd;
   logic [LEN_WIDTH-1:0]  rd_len;
   logic                  err_clr;
   logic                  wr_ack;
   logic                  rd_ack;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   count;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr, wr_len, rd, rd_len, err_clr,
      input  wr_ack, rd_ack, w_addr, r_addr, count,
             empty, full, almost_empty, almost_full, overflow, underflow
   );

   modport slave (
      input  wr, wr_len, rd, rd_len, err_clr,
      output wr_ack, rd_ack, w_addr, r_addr, count,
             empty, full, almost_empty, almost_full, overflow, underflow
   );
endinterface

// File: rtl/fifo_burst_ctrl.sv
// Circular-queue controller for burst-accessed register-file FIFOs: all-or-nothing bursts, occupancy and flags.
// Define FIFO_BURST_ERR_EN to build the sticky overflow/underflow error flags.
`timescale 1ns/1ps

module fifo_burst_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int MAX_BURST  = 4,
   parameter int LEN_WIDTH  = 3,
   parameter int AF_MARGIN  = 2,
   parameter int AE_MARGIN  = 2
) (
   input  logic               clk,
   input  logic               reset,
   fifo_burst_ctrl_if.slave   io_fifo
);

   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam int CW        = ((ADDR_WIDTH + 1) > LEN_WIDTH ? (ADDR_WIDTH + 1) : LEN_WIDTH) + 1;
   localparam int AF_THRESH = (AF_MARGIN >= DEPTH) ? 0 : (DEPTH - AF_MARGIN);
   localparam int AE_THRESH = (AE_MARGIN > DEPTH) ? DEPTH : AE_MARGIN;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_almost_empty;
   logic                  r_almost_full;

   logic [CW-1:0] w_wr_len_x;
   logic [CW-1:0] w_rd_len_x;
   logic [CW-1:0] w_count_x;
   logic [CW-1:0] w_free_x;
   logic [CW-1:0] w_count_next;
   logic          w_wr_ack;
   logic          w_rd_ack;

   // Everything is widened to CW so DEPTH, count and lengths compare without truncation.
   assign w_wr_len_x = CW'(io_fifo.wr_len);
   assign w_rd_len_x = CW'(io_fifo.rd_len);
   assign w_count_x  = CW'(r_count);
   assign w_free_x   = CW'(DEPTH) - w_count_x;

   // Each ack looks only at its own request and the registered count, so rd never reaches wr_ack.
   assign w_wr_ack = io_fifo.wr && (w_wr_len_x != '0) &&
                     (w_wr_len_x <= CW'(MAX_BURST)) && (w_wr_len_x <= w_free_x);
   assign w_rd_ack = io_fifo.rd && (w_rd_len_x != '0) &&
                     (w_rd_len_x <= CW'(MAX_BURST)) && (w_rd_len_x <= w_count_x);

   assign w_count_next = w_count_x + (w_wr_ack ? w_wr_len_x : '0) - (w_rd_ack ? w_rd_len_x : '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_empty        <= 1'b1;
         r_full         <= 1'b0;
         r_almost_empty <= 1'b1;
         r_almost_full  <= (AF_THRESH == 0);
      end else begin
         if (w_wr_ack) r_wr_ptr <= r_wr_ptr + w_wr_len_x[ADDR_WIDTH-1:0];
         if (w_rd_ack) r_rd_ptr <= r_rd_ptr + w_rd_len_x[ADDR_WIDTH-1:0];
         r_count        <= w_count_next[ADDR_WIDTH:0];
         r_empty        <= (w_count_next == '0);
         r_full         <= (w_count_next == CW'(DEPTH));
         r_almost_empty <= (w_count_next <= CW'(AE_THRESH));
         r_almost_full  <= (w_count_next >= CW'(AF_THRESH));
      end
   end

   assign io_fifo.wr_ack       = w_wr_ack;
   assign io_fifo.rd_ack       = w_rd_ack;
   assign io_fifo.w_addr       = r_wr_ptr;
   assign io_fifo.r_addr       = r_rd_ptr;
   assign io_fifo.count        = r_count;
   assign io_fifo.empty        = r_empty;
   assign io_fifo.full         = r_full;
   assign io_fifo.almost_empty = r_almost_empty;
   assign io_fifo.almost_full  = r_almost_full;

`ifdef FIFO_BURST_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // err_clr beats a same-cycle set so software never misses a clear.
   always_ff @(posedge clk) begin
      if (reset || io_fifo.err_clr) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (io_fifo.wr && !w_wr_ack) r_overflow  <= 1'b1;
         if (io_fifo.rd && !w_rd_ack) r_underflow <= 1'b1;
      end
   end

   assign io_fifo.overflow  = r_overflow;
   assign io_fifo.underflow = r_underflow;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr  = io_fifo.err_clr;
   assign io_fifo.overflow  = 1'b0;
   assign io_fifo.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed-vector bench for fifo_burst_ctrl: the driver queues hand-computed expectations, a monitor checks them.
// Error-flag expectations are masked off when FIFO_BURST_ERR_EN is not defined.
`timescale 1ns/1ps

module tb_fifo_burst_ctrl;

`ifdef FIFO_BURST_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   typedef struct {
      logic       wack;
      logic       rack;
      logic [3:0] waddr;
      logic [3:0] raddr;
      logic [4:0] count;
      logic       empty;
      logic       full;
      logic       ae;
      logic       af;
      logic       ov;
      logic       un;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb_q[$];
   logic tb_valid = 1'b0;
   int   total = 0;
   int   bad   = 0;

   fifo_burst_ctrl_if #(.ADDR_WIDTH(4), .LEN_WIDTH(3)) bus ();

   fifo_burst_ctrl #(
      .ADDR_WIDTH(4), .MAX_BURST(4), .LEN_WIDTH(3), .AF_MARGIN(2), .AE_MARGIN(2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .io_fifo (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One request cycle: inputs driven on the falling edge, expectation queued for the monitor.
   task automatic step(input logic rst, input logic wr, input int wl, input logic rd, input int rl,
                       input logic clr, input logic wack, input logic rack, input int waddr,
                       input int raddr, input int cnt, input logic e, input logic f,
                       input logic ae, input logic af, input logic ov, input logic un);
      exp_t it;
      @(negedge clk);
      reset       = rst;
      bus.wr      = wr;
      bus.wr_len  = 3'(wl);
      bus.rd      = rd;
      bus.rd_len  = 3'(rl);
      bus.err_clr = clr;
      it.wack  = wack;
      it.rack  = rack;
      it.waddr = 4'(waddr);
      it.raddr = 4'(raddr);
      it.count = 5'(cnt);
      it.empty = e;
      it.full  = f;
      it.ae    = ae;
      it.af    = af;
      it.ov    = ov & ERR;
      it.un    = un & ERR;
      sb_q.push_back(it);
      tb_valid = 1'b1;
   endtask

   // Monitor: acks/addresses sampled late in the request cycle, status just after the edge.
   initial begin
      exp_t it;
      forever begin
         @(negedge clk);
         #3;
         if (tb_valid) begin
            if (sb_q.size() == 0) begin
               check("scoreboard_underrun", 32'd1, 32'd0);
            end else begin
               it = sb_q.pop_front();
               check("wr_ack", 32'(bus.wr_ack), 32'(it.wack));
               check("rd_ack", 32'(bus.rd_ack), 32'(it.rack));
               check("w_addr", 32'(bus.w_addr), 32'(it.waddr));
               check("r_addr", 32'(bus.r_addr), 32'(it.raddr));
               @(posedge clk);
               #1;
               check("count",        32'(bus.count),        32'(it.count));
               check("empty",        32'(bus.empty),        32'(it.empty));
               check("full",         32'(bus.full),         32'(it.full));
               check("almost_empty", 32'(bus.almost_empty), 32'(it.ae));
               check("almost_full",  32'(bus.almost_full),  32'(it.af));
               check("overflow",     32'(bus.overflow),     32'(it.ov));
               check("underflow",    32'(bus.underflow),    32'(it.un));
            end
         end
      end
   end

   initial begin
      reset       = 1'b1;
      bus.wr      = 1'b0;
      bus.wr_len  = '0;
      bus.rd      = 1'b0;
      bus.rd_len  = '0;
      bus.err_clr = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      step(1,0,0,0,0,0, 0,0, 0,0,  0,1,0,1,0,0,0);

      // Fill with four 4-bursts, overflow, clear, full read+write, boundary lengths
      step(0,1,4,0,0,0, 1,0, 0,0,  4,0,0,0,0,0,0);
      step(0,1,4,0,0,0, 1,0, 4,0,  8,0,0,0,0,0,0);
      step(0,1,4,0,0,0, 1,0, 8,0, 12,0,0,0,0,0,0);
      step(0,1,4,0,0,0, 1,0,12,0, 16,0,1,0,1,0,0);
      step(0,1,1,0,0,0, 0,0, 0,0, 16,0,1,0,1,1,0);
      step(0,0,0,0,0,1, 0,0, 0,0, 16,0,1,0,1,0,0);
      step(0,1,2,1,2,0, 0,1, 0,0, 14,0,0,0,1,1,0);
      step(0,1,0,0,0,1, 0,0, 0,2, 14,0,0,0,1,0,0);
      step(0,1,5,0,0,0, 0,0, 0,2, 14,0,0,0,1,1,0);
      step(0,0,0,1,2,0, 0,1, 0,2, 12,0,0,0,0,1,0);
      step(0,1,4,0,0,0, 1,0, 0,4, 16,0,1,0,1,1,0);
      step(0,0,0,0,0,1, 0,0, 4,4, 16,0,1,0,1,0,0);
      step(1,0,0,0,0,0, 0,0, 4,4,  0,1,0,1,0,0,0);

      // Underflow on over-long read, exact drain, read+write on empty
      step(0,1,3,0,0,0, 1,0, 0,0,  3,0,0,0,0,0,0);
      step(0,0,0,1,4,0, 0,0, 3,0,  3,0,0,0,0,0,1);
      step(0,0,0,1,3,0, 0,1, 3,0,  0,1,0,1,0,0,1);
      step(0,0,0,0,0,1, 0,0, 3,3,  0,1,0,1,0,0,0);
      step(0,1,1,1,1,0, 1,0, 3,3,  1,0,0,1,0,0,1);
      step(0,0,0,1,1,0, 0,1, 4,3,  0,1,0,1,0,0,1);
      step(1,0,0,0,0,0, 0,0, 4,4,  0,1,0,1,0,0,0);

      // Pointer wrap-around: pointers walk 0,4,8,12,0 and end on 4
      for (int i = 0; i < 5; i++) begin
         step(0,1,4,0,0,0, 1,0, (4*i)%16,     (4*i)%16, 4,0,0,0,0,0,0);
         step(0,0,0,1,4,0, 0,1, (4*i+4)%16,   (4*i)%16, 0,1,0,1,0,0,0);
      end
      step(0,0,0,0,0,0, 0,0, 4,4,  0,1,0,1,0,0,0);

      // Reach count 9 with both errors set, then reset during an acked 3-entry write
      step(0,1,4,0,0,0, 1,0, 4,4,  4,0,0,0,0,0,0);
      step(0,1,4,0,0,0, 1,0, 8,4,  8,0,0,0,0,0,0);
      step(0,1,1,0,0,0, 1,0,12,4,  9,0,0,0,0,0,0);
      step(0,1,5,1,0,0, 0,0,13,4,  9,0,0,0,0,1,1);
      step(1,1,3,0,0,0, 1,0,13,4,  0,1,0,1,0,0,0);
      step(0,0,0,0,0,0, 0,0, 0,0,  0,1,0,1,0,0,0);

      // almost_empty edge at count 2 and 3
      step(0,1,2,0,0,0, 1,0, 0,0,  2,0,0,1,0,0,0);
      step(0,1,1,0,0,0, 1,0, 2,0,  3,0,0,0,0,0,0);

      @(negedge clk);
      tb_valid    = 1'b0;
      bus.wr      = 1'b0;
      bus.rd      = 1'b0;
      bus.err_clr = 1'b0;

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
